// File: rtl/pwl_dec_sampler.sv
// pwl_dec_sampler: evaluates a PWL node at each clk edge, quantizes it to NBIT and emits decimated averages.
// Define PWL_DEC_SAMPLER_SAT_EN to add the `sat` output flagging windows that contained a clamped sample.
module pwl_dec_sampler #(
    parameter real vlo    = 0.0,
    parameter real vhi    = 1.0,
    parameter int  NBIT   = 8,
    parameter int  DEC    = 4,
    parameter int  SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    // PWL segment as IEEE-754 doubles: {offset [V], slope [V/ns], t0 [ns]}
    input  logic [191:0]    in,
    input  logic            en,
    output logic [NBIT-1:0] code,
    output logic            valid
`ifdef PWL_DEC_SAMPLER_SAT_EN
    ,
    output logic            sat
`endif
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int  AW   = NBIT + $clog2(DEC) + 1;
    localparam int  CW   = $clog2(DEC + 1);
    localparam int  SW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam real FULL = 2.0 ** NBIT;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_ACC    = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [SW-1:0] scnt;

    // Input voltage at time t, scaled so that one code step is 1.0.
    function automatic real scaled(input logic [191:0] p, input real t);
        real v;
        v = $bitstoreal(p[191:128]) + $bitstoreal(p[127:64]) * (t - $bitstoreal(p[63:0]));
        return (v - vlo) / (vhi - vlo) * FULL;
    endfunction

    // A NaN fails every comparison, so it lands on code 0 instead of poisoning the accumulator.
    function automatic logic [NBIT-1:0] quant(input real x);
        if (!(x >= 0.0)) return '0;
        if (x >= FULL)   return '1;
        return NBIT'($rtoi($floor(x)));
    endfunction

`ifdef PWL_DEC_SAMPLER_SAT_EN
    logic sat_acc;

    function automatic logic is_clamped(input real x);
        return !(x >= 0.0 && x < FULL);
    endfunction
`endif

    // NOTE: the PWL is evaluated inside the clocked block so $realtime is the edge time;
    // a combinational evaluation would only re-run when `in` changes and go stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            code  <= '0;
            valid <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            scnt  <= '0;
`ifdef PWL_DEC_SAMPLER_SAT_EN
            sat     <= 1'b0;
            sat_acc <= 1'b0;
`endif
        end else if (!en) begin
            // Enable drop abandons the partial window; code keeps the last average.
            state <= ST_IDLE;
            valid <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            scnt  <= '0;
`ifdef PWL_DEC_SAMPLER_SAT_EN
            sat     <= 1'b0;
            sat_acc <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= (SETTLE > 0) ? ST_SETTLE : ST_ACC;
`ifdef PWL_DEC_SAMPLER_SAT_EN
                    sat <= 1'b0;
`endif
                end
                ST_SETTLE: begin
                    if (scnt == SW'(SETTLE - 1)) begin
                        state <= ST_ACC;
                        scnt  <= '0;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                ST_ACC: begin
                    if (cnt == CW'(DEC - 1)) begin
                        code  <= NBIT'((acc + AW'(quant(scaled(in, $realtime)))) / AW'(DEC));
                        valid <= 1'b1;
                        acc   <= '0;
                        cnt   <= '0;
`ifdef PWL_DEC_SAMPLER_SAT_EN
                        sat     <= sat_acc | is_clamped(scaled(in, $realtime));
                        sat_acc <= 1'b0;
`endif
                    end else begin
                        acc <= acc + AW'(quant(scaled(in, $realtime)));
                        cnt <= cnt + 1'b1;
`ifdef PWL_DEC_SAMPLER_SAT_EN
                        sat_acc <= sat_acc | is_clamped(scaled(in, $realtime));
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwl_dec_sampler.sv
// tb_pwl_dec_sampler: directed scenarios for pwl_dec_sampler with default parameters (8 bit, DEC=4, SETTLE=2).
// Runs with or without PWL_DEC_SAMPLER_SAT_EN; sat checks only exist when the port does.
module tb_pwl_dec_sampler;
    timeunit 1ns;
    timeprecision 1ps;

    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] pwl_in;
    logic         en;
    logic [7:0]   code;
    logic         valid;
`ifdef PWL_DEC_SAMPLER_SAT_EN
    logic         sat;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int c1;

    pwl_dec_sampler dut (
        .clk  (clk),
        .rst  (rst),
        .in   (pwl_in),
        .en   (en),
        .code (code),
        .valid(valid)
`ifdef PWL_DEC_SAMPLER_SAT_EN
        ,
        .sat  (sat)
`endif
    );

    // 10 MHz sampling clock
    always #50 clk = ~clk;

    function automatic logic [191:0] make_pwl(input real off, input real slope, input real t0);
        return {$realtobits(off), $realtobits(slope), $realtobits(t0)};
    endfunction

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then park on the falling edge where outputs are stable.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Steps until valid, checking the edge count and that code never moved in between.
    task automatic wait_valid(input string tag, input int exp_edges);
        int         n     = 0;
        logic [7:0] held  = code;
        bit         moved = 1'b0;
        do begin
            step();
            n++;
            if (!valid && code !== held) moved = 1'b1;
        end while (!valid && n < 40);
        check({tag, "_edges"}, valid ? n : -1, exp_edges);
        check({tag, "_hold"}, moved, 0);
    endtask

    task automatic restart();
        en = 1'b0;
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        pwl_in = make_pwl(0.0, 0.0, 0.0);
        @(negedge clk);
        step();
        step();
        check("rst_code", code, 0);
        check("rst_valid", valid, 0);
`ifdef PWL_DEC_SAMPLER_SAT_EN
        check("rst_sat", sat, 0);
`endif
        rst = 1'b0;

        // Constant 0.5 V: en sampled on edge 0, two discarded, valid on edge 6 then every 4.
        pwl_in = make_pwl(0.5, 0.0, $realtime);
        en     = 1'b1;
        step();
        check("const_edge0_valid", valid, 0);
        wait_valid("const_first", 6);
        check("const_code1", code, 128);
        step();
        check("const_strobe_width", valid, 0);
        wait_valid("const_second", 3);
        check("const_code2", code, 128);

        // Ramp at 1 V/us reaching 0 V 20 ns before the first accumulated edge:
        // window 1 = 0.02/0.12/0.22/0.32 V -> 5+30+56+81 = 172 -> 43
        // window 2 = 0.42/0.52/0.62/0.72 V -> 107+133+158+184 = 582 -> 145
        restart();
        check("ramp_idle_valid", valid, 0);
        check("ramp_idle_code", code, 128);
        pwl_in = make_pwl(0.0, 0.001, $realtime + 330.0);
        en     = 1'b1;
        step();
        check("ramp_edge0_valid", valid, 0);
        wait_valid("ramp_w1", 6);
        check("ramp_code1", code, 43);
        c1 = int'(code);
        wait_valid("ramp_w2", 4);
        check("ramp_code2", code, 145);
        check("ramp_delta", int'(code) - c1, 102);

        // Over-range, under-range, then back in range.
        restart();
        pwl_in = make_pwl(1.2, 0.0, $realtime);
        en     = 1'b1;
        step();
        wait_valid("over", 6);
        check("over_code", code, 255);
`ifdef PWL_DEC_SAMPLER_SAT_EN
        check("over_sat", sat, 1);
`endif
        pwl_in = make_pwl(-0.1, 0.0, $realtime);
        wait_valid("under", 4);
        check("under_code", code, 0);
`ifdef PWL_DEC_SAMPLER_SAT_EN
        check("under_sat", sat, 1);
`endif
        pwl_in = make_pwl(0.5, 0.0, $realtime);
        wait_valid("inrange", 4);
        check("inrange_code", code, 128);
`ifdef PWL_DEC_SAMPLER_SAT_EN
        check("inrange_sat", sat, 0);
`endif

        // Enable drop after two samples of a 0.25 V window.
        pwl_in = make_pwl(0.25, 0.0, $realtime);
        step();
        step();
        check("drop_pre_valid", valid, 0);
        en = 1'b0;
        step();
        check("drop_valid", valid, 0);
        check("drop_code_hold", code, 128);
        step();
        step();
        check("drop_idle_valid", valid, 0);
        check("drop_idle_code", code, 128);
        en = 1'b1;
        step();
        check("reen_edge0_valid", valid, 0);
        wait_valid("reen", 6);
        check("reen_code", code, 64);

        // Reset on the third edge of a 0.75 V window.
        pwl_in = make_pwl(0.75, 0.0, $realtime);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_code", code, 0);
        check("midrst_valid", valid, 0);
`ifdef PWL_DEC_SAMPLER_SAT_EN
        check("midrst_sat", sat, 0);
`endif
        rst = 1'b0;
        step();
        check("postrst_edge0_valid", valid, 0);
        wait_valid("postrst", 6);
        check("postrst_code", code, 192);

        // Slope change landing exactly on a sampling edge; both sides read 0.5 V there:
        // 0.50/0.55/0.60/0.65 V -> 128+140+153+166 = 587 -> 146
        pwl_in = make_pwl(0.5, 0.0, $realtime);
        @(posedge clk);
        pwl_in = make_pwl(0.5, 0.0005, $realtime);
        @(negedge clk);
        check("coinc_first_valid", valid, 0);
        wait_valid("coinc", 3);
        check("coinc_code", code, 146);
        check("coinc_code_known", $isunknown(code), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwl_dec_sampler.md
PWL_DEC_SAMPLER -- requirements
Module: pwl_dec_sampler

Interface
REQ-001 SHALL have parameter vlo, real, default 0.0: input voltage mapped to code 0.
REQ-002 SHALL have parameter vhi, real, default 1.0: full-scale voltage, with vhi > vlo.
REQ-003 SHALL have parameter NBIT, integer, default 8: output code width, range 2..16.
REQ-004 SHALL have parameter DEC, integer, default 4: samples per output word, range 1..256.
REQ-005 SHALL have parameter SETTLE, integer, default 2: samples discarded after entering the run state, range 0..255.
REQ-006 SHALL have port clk, input, 1 bit: single sampling clock, rising-edge active.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in, input_pwl: PWL signal, typically an event-filtered analog node.
REQ-009 SHALL have port en, input, 1 bit: run enable, sampled on clk.
REQ-010 SHALL have port code, output, NBIT bits: decimated average code.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle strobe marking a new code.

Function
REQ-012 SHALL evaluate in at each rising clk edge at the current real time, using the PWL evaluation method: v = offset + slope*(t - t0).
REQ-013 SHALL quantize each sample as q = floor((v-vlo)/(vhi-vlo)*2^NBIT), then clamp to 0..2^NBIT-1.
REQ-014 SHALL implement a state machine with three states: IDLE, SETTLE, ACC.
REQ-015 SHALL handle IDLE as follows: if en=1, go to SETTLE when SETTLE>0, otherwise go to ACC; no samples are accumulated in IDLE.
REQ-016 SHALL handle SETTLE as follows: count edges; after SETTLE edges have been discarded, go to ACC.
REQ-017 SHALL handle ACC as follows: add q to an accumulator of width NBIT+ceil(log2(DEC))+1 and increment the sample counter.
REQ-018 SHALL, on the edge that captures the DEC-th sample, load code = floor(acc_total/DEC), assert valid, clear acc and the counter, and remain in ACC.
REQ-019 SHALL drive valid high for exactly one clk cycle per completed window, and SHALL never assert valid on two consecutive edges unless DEC=1.
REQ-020 SHALL, when en=0 is sampled in any state, go to IDLE, discard the partial window, clear acc and counters, hold code, and keep valid=0.
REQ-021 SHALL treat en toggling 1->0->1 as a full restart, including a new SETTLE phase.
REQ-022 SHALL hold code constant between valid strobes.
REQ-023 SHALL keep the last event time and value from in valid across clock edges, so that events with zero-delay ordering relative to clk do not corrupt a sample.
REQ-024 SHALL sample the value at the edge time when an in event and a clk edge coincide; either the pre-event or post-event value is acceptable, provided the difference is at most |slope change|*1 timeunit.

Reset
REQ-025 SHALL, on a rising clk edge with rst=1, set state=IDLE, code=0, valid=0, acc=0, and all counters=0, and SAT (if built) =0.
REQ-026 SHALL, when rst is asserted mid-window, discard the partial accumulation and emit no valid.
REQ-027 SHALL give rst priority over en.
REQ-028 SHALL, after rst deasserts with en=1, begin SETTLE on the next edge.

Configuration
REQ-029 SHALL compile in the saturation flag when macro PWL_DEC_SAMPLER_SAT_EN is defined: add output port sat, 1 bit.
REQ-030 SHALL, with PWL_DEC_SAMPLER_SAT_EN defined, set sat together with valid when any sample in that window was clamped by REQ-013; sat SHALL hold until the next valid, and SHALL be cleared by reset and in IDLE.
REQ-031 SHALL, without PWL_DEC_SAMPLER_SAT_EN, have no sat port and no clamp tracking; clamping itself remains unchanged.

Verification
REQ-032 SHALL cover constant input, with parameters vlo=0, vhi=1, NBIT=8, DEC=4, SETTLE=2, in=0.5 V constant, en=1 after reset: first valid on the 6th edge after en is sampled, with code=128, then valid every 4 edges.
REQ-033 SHALL cover a ramp: in ramps 0 -> 1 V at 1 V/us, clk 10 MHz, DEC=4; consecutive codes increase by 102±1, and no valid appears during SETTLE.
REQ-034 SHALL cover over-range and under-range: in=1.2 V gives code=255 and sat=1 (macro on); in=-0.1 V gives code=0 and sat=1; in=0.5 V in the next window gives sat=0.
REQ-035 SHALL cover enable drop: en deasserted after 2 samples of a window; no valid appears, code holds the prior value, and re-enable requires 2+4 edges before the next valid.
REQ-036 SHALL cover reset mid-window: rst asserted for 1 cycle on edge 3 of ACC; code=0, valid=0, and the next valid occurs 6 edges after rst releases.
REQ-037 SHALL cover coincident events: a PWL event scheduled at the exact clk edge time; the sampled code matches the pre-event or post-event value per REQ-024, with no X or NaN on code.
